// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared widths, constants and types for the 16-bit CPU front end.
//   WORD_W / IF_ID_W : instruction word and IF/ID register widths
//   NOP_INSTR        : bubble instruction word
//   RESET_PC_DEFAULT : default first fetch address
//   fetch_state_e    : instruction-fetch request FSM states
//   if_id_t          : {pc_plus_1, instruction} payload carried into decode
package cpu16_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned IF_ID_W    = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  localparam logic [WORD_W-1:0] NOP_INSTR        = 16'h0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE             = 2'd0,
    WAIT_ACK         = 2'd1,
    WAIT_ACK_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc_plus_1;
    logic [WORD_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory read handshake.
//   imem_req/imem_addr  : request and word address (fetch side drives)
//   imem_ack/imem_rdata : completion and instruction word (memory side drives)
interface if_stage_if;
  import cpu16_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/if_prefetch_fifo.sv
// if_prefetch_fifo: 2-entry prefetch buffer of {pc_plus_1, instruction} pairs.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write one entry (caller guarantees not full)
//   pop        : drop head (caller guarantees not empty)
//   clear      : empty the buffer, takes priority over push/pop
//   head_c     : current head entry (combinational read)
//   count      : occupancy 0..2
module if_prefetch_fifo
  import cpu16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  if_id_t           wdata,
  output if_id_t           head_c,
  output logic [CNT_W-1:0] count
);

  if_id_t mem [FIFO_DEPTH];
  logic   rd_ptr;
  logic   wr_ptr;

  assign head_c = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding request, 2-entry prefetch
// buffer and the IF/ID pipeline register.
//   clk, pc_reset  : clock, async active-low reset
//   imem           : instruction-memory handshake (master side)
//   if_id_write    : 1 = IF/ID may advance, 0 = hold
//   if_id_flush    : insert bubble into IF/ID
//   branch_taken   : redirect fetch to branch_target, drop prefetched words
//   if_id_pipe     : {pc_plus_1, instruction} to decode
//   if_id_valid    : if_id_pipe holds a real instruction
module if_stage
  import cpu16_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               pc_reset,
  if_stage_if.master         imem,
  input  logic               if_id_write,
  input  logic               if_id_flush,
  input  logic               branch_taken,
  input  logic [WORD_W-1:0]  branch_target,
  output logic [IF_ID_W-1:0] if_id_pipe,
  output logic               if_id_valid
);

  localparam if_id_t BUBBLE = '{pc_plus_1: '0, instr: NOP_INSTR};

  fetch_state_e      state, state_next;
  logic [WORD_W-1:0] fetch_pc, fetch_pc_next;
  logic [WORD_W-1:0] addr_next;
  logic              req_next;
  if_id_t            pipe_q, pipe_next;
  logic              valid_next;

  logic              ack_fire;
  logic              outstanding_after;
  logic              issue;
  logic              fifo_push, fifo_pop, fifo_clear;
  if_id_t            fifo_wdata, fifo_head_c;
  logic [CNT_W-1:0]  fifo_count, count_next;

  assign if_id_pipe = pipe_q;
  assign fifo_wdata = '{pc_plus_1: imem.imem_addr + WORD_W'(1), instr: imem.imem_rdata};

  if_prefetch_fifo u_fifo (
    .clk    (clk),
    .rst_n  (pc_reset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .clear  (fifo_clear),
    .wdata  (fifo_wdata),
    .head_c (fifo_head_c),
    .count  (fifo_count)
  );

  // State and output registers
  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_PC;
      pipe_q         <= BUBBLE;
      if_id_valid    <= 1'b0;
    end else begin
      state          <= state_next;
      fetch_pc       <= fetch_pc_next;
      imem.imem_req  <= req_next;
      imem.imem_addr <= addr_next;
      pipe_q         <= pipe_next;
      if_id_valid    <= valid_next;
    end
  end

  // Request FSM, buffer control and IF/ID next values
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_next      = imem.imem_req;
    addr_next     = imem.imem_addr;
    pipe_next     = pipe_q;
    valid_next    = if_id_valid;

    ack_fire   = imem.imem_req && imem.imem_ack;
    // Data returning for a request issued before a branch is dropped.
    fifo_push  = ack_fire && (state == WAIT_ACK) && !branch_taken;
    fifo_pop   = if_id_write && !if_id_flush && !branch_taken && (fifo_count != '0);
    fifo_clear = branch_taken;

    count_next = fifo_count;
    if (fifo_clear)                 count_next = '0;
    else if (fifo_push && !fifo_pop) count_next = fifo_count + CNT_W'(1);
    else if (!fifo_push && fifo_pop) count_next = fifo_count - CNT_W'(1);

    // A new request may go out on the ack edge of the previous one.
    outstanding_after = (state != IDLE) && !ack_fire;
    issue = !branch_taken && !outstanding_after && (count_next < CNT_W'(FIFO_DEPTH));

    if (issue) begin
      state_next    = WAIT_ACK;
      req_next      = 1'b1;
      addr_next     = fetch_pc;
      fetch_pc_next = fetch_pc + WORD_W'(1);
    end else if (outstanding_after) begin
      state_next = branch_taken ? WAIT_ACK_DISCARD : state;
    end else begin
      state_next = IDLE;
      req_next   = 1'b0;
    end

    if (branch_taken) fetch_pc_next = branch_target;

    if (branch_taken || if_id_flush) begin
      pipe_next  = BUBBLE;
      valid_next = 1'b0;
    end else if (if_id_write) begin
      if (fifo_count != '0) begin
        pipe_next  = fifo_head_c;
        valid_next = 1'b1;
      end else begin
        pipe_next  = BUBBLE;
        valid_next = 1'b0;
      end
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, word address fetched first after reset.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: pc_reset  input  1  reset, asynchronous, active-low.
REQ-004 Port: imem_req  output  1  instruction-memory read request, registered.
REQ-005 Port: imem_addr  output  16  word address of the outstanding request, registered.
REQ-006 Port: imem_ack  input  1  transfer completes on an edge where imem_req && imem_ack.
REQ-007 Port: imem_rdata  input  16  instruction word, valid with imem_ack.
REQ-008 Port: if_id_write  input  1  1 = IF/ID register may advance; 0 = hold (load-use stall).
REQ-009 Port: if_id_flush  input  1  synchronous bubble insert into IF/ID.
REQ-010 Port: branch_taken  input  1  redirect fetch to branch_target.
REQ-011 Port: branch_target  input  16  redirect word address.
REQ-012 Port: if_id_pipe  output  32  {pc_plus_1[31:16], instruction[15:0]} consumed by decode.
REQ-013 Port: if_id_valid  output  1  if_id_pipe holds a real instruction.

Function
REQ-014 fetch_pc SHALL be word-addressed, +1 per issued request, wrapping 16'hFFFF -> 16'h0000.
REQ-015 At most one request SHALL be outstanding; imem_req and imem_addr SHALL stay stable from assertion until the ack edge.
REQ-016 A 2-entry prefetch buffer SHALL hold {pc_plus_1, instruction} pairs in fetch order.
REQ-017 A new request SHALL be issued only when occupancy + outstanding < 2; imem_req drops on the ack edge otherwise.
REQ-018 On the ack edge the returned word SHALL be written to the buffer with pc_plus_1 = imem_addr + 1 (wrapping).
REQ-019 Latency: instruction acked at edge N SHALL appear in if_id_pipe at edge N+1 at earliest; no combinational bypass.
REQ-020 On an edge with if_id_write=1 and buffer non-empty: head -> if_id_pipe, if_id_valid=1, head popped.
REQ-021 On an edge with if_id_write=1 and buffer empty: if_id_pipe=32'h0 (NOP), if_id_valid=0.
REQ-022 On an edge with if_id_write=0: if_id_pipe, if_id_valid and buffer head SHALL hold; fetch continues until full.
REQ-023 Priority for IF/ID: branch_taken > if_id_flush > if_id_write; flush or branch loads 32'h0, valid=0, regardless of if_id_write.
REQ-024 branch_taken SHALL empty the buffer and set fetch_pc = branch_target on the same edge.
REQ-025 branch_taken with a request outstanding and unacked: the request completes normally, its data SHALL be discarded, then branch_target is requested.
REQ-026 branch_taken on the ack edge: returned data SHALL be discarded; next request is branch_target.
REQ-027 Push and pop on the same edge with buffer full SHALL be impossible by REQ-017; with occupancy 1 both SHALL occur, occupancy stays 1.
REQ-028 if_id_flush alone SHALL NOT disturb the buffer or fetch_pc.

Reset
REQ-029 pc_reset low SHALL immediately force: fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, buffer empty, discard flag clear, if_id_pipe=32'h0, if_id_valid=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a late imem_ack while in reset is ignored.
REQ-031 imem_req SHALL assert at the first rising edge after pc_reset returns high, with imem_addr=RESET_PC.

Structure
REQ-032 Shared package cpu16_pkg SHALL hold WORD_W=16, IF_ID_W=32, NOP_INSTR=16'h0000, RESET_PC default.
REQ-033 Prefetch buffer SHALL be sub-module if_prefetch_fifo (2 entries, 32 bits, push/pop/clear, count).
REQ-034 IF/ID register and request FSM (IDLE, WAIT_ACK, WAIT_ACK_DISCARD) SHALL reside in if_stage.

Verification
REQ-035 Reset release, imem_ack tied 1, rdata=addr^16'hA5A5 -> imem_addr 0,1,2...; if_id_pipe {16'h0001,16'hA5A5} one edge after first ack.
REQ-036 if_id_write=0 for 5 cycles -> if_id_pipe held, exactly 2 further requests issued then imem_req=0; release -> buffered words drain in order.
REQ-037 branch_taken, target 16'h0040, while request for 16'h0003 unacked with ack delayed 3 cycles -> 16'h0003 data dropped, next imem_addr=16'h0040, if_id_pipe=0/valid=0 meanwhile.
REQ-038 branch_taken coincident with ack and if_id_flush -> IF/ID=32'h0, buffer empty, returned word never appears.
REQ-039 Fetch from 16'hFFFF -> pc_plus_1=16'h0000, next imem_addr=16'h0000.
REQ-040 pc_reset asserted mid-WAIT_ACK with buffer full -> all outputs at reset values immediately; restart at RESET_PC.
